// File: rtl/tx_data_stream_cross.sv
// Egress serializer for one switch port: wide cross-bus frames in, MAC byte stream out.
// Frames starting while the link is down are consumed silently; sent frames raise a timestamp irq.
//
// state | meaning
// IDLE  | no frame in progress, word buffer empty
// SEND  | serializing the current frame onto the MAC stream
// DROP  | link was down at frame start, beats consumed with no output
module tx_data_stream_cross #(
    parameter int PORT_NUM            = 4,
    parameter int PORT_MNG_DATA_WIDTH = 8,
    parameter int CROSS_DATA_WIDTH    = PORT_MNG_DATA_WIDTH * PORT_NUM,
    parameter int TS_ADDR_DEPTH       = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_mac_port_link,
    input  logic [CROSS_DATA_WIDTH:0]     i_mac_cross_port_axi_data,
    input  logic [CROSS_DATA_WIDTH/8-1:0] i_mac_cross_axi_data_keep,
    input  logic                          i_mac_cross_axi_data_valid,
    output logic                          o_mac_cross_axi_data_ready,
    input  logic                          i_mac_cross_axi_data_last,
    output logic [7:0]                    o_mac_axi_data,
    output logic                          o_mac_axi_data_keep,
    output logic                          o_mac_axi_data_valid,
    input  logic                          i_mac_axi_data_ready,
    output logic                          o_mac_axi_data_last,
    output logic                          o_mac_axi_data_err,
    output logic                          o_mac_time_irq,
    output logic [7:0]                    o_mac_frame_seq,
    output logic [7:0]                    o_timestamp_addr,
    output logic [15:0]                   o_port_tx_byte_cnt,
    output logic [15:0]                   o_port_tx_frame_cnt
);

    localparam int BYTES = CROSS_DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES + 1);

    typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

    state_t                      state_q, state_d;
    logic [CROSS_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                        buf_valid_q, buf_valid_d;
    logic                        buf_last_q, buf_last_d;
    logic [CW-1:0]               byte_idx_q, byte_idx_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        err_acc_q, err_acc_d;
    logic                        first_byte_q, first_byte_d;
    logic                        irq_q, irq_d;
    logic [7:0]                  seq_cnt_q, seq_cnt_d;
    logic [7:0]                  addr_cnt_q, addr_cnt_d;
    logic [7:0]                  seq_out_q, seq_out_d;
    logic [7:0]                  addr_out_q, addr_out_d;
    logic [15:0]                 byte_cnt_q, byte_cnt_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;

    logic          ready;
    logic          accept;
    logic          out_hs;
    logic          last_byte;
    logic          new_frame;
    logic          err_in;
    logic [CW-1:0] keep_cnt;

    assign err_in    = i_mac_cross_port_axi_data[CROSS_DATA_WIDTH];
    assign out_hs    = buf_valid_q & i_mac_axi_data_ready;
    assign last_byte = (byte_idx_q == cnt_q - CW'(1));
    assign ready     = ~i_rst & ((state_q == DROP) | ~buf_valid_q | (last_byte & out_hs));
    assign accept    = i_mac_cross_axi_data_valid & ready;
    // A beat accepted while the buffer holds a last beat opens the next frame back-to-back.
    assign new_frame = (state_q == IDLE) | ((state_q == SEND) & buf_last_q);

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_cnt = keep_cnt + CW'(i_mac_cross_axi_data_keep[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_data_d   = buf_data_q;
        buf_valid_d  = buf_valid_q;
        buf_last_d   = buf_last_q;
        byte_idx_d   = byte_idx_q;
        cnt_d        = cnt_q;
        err_acc_d    = err_acc_q;
        first_byte_d = first_byte_q;
        seq_cnt_d    = seq_cnt_q;
        addr_cnt_d   = addr_cnt_q;
        seq_out_d    = seq_out_q;
        addr_out_d   = addr_out_q;
        byte_cnt_d   = byte_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        irq_d        = out_hs & first_byte_q;

        if (out_hs) begin
            first_byte_d = 1'b0;
            byte_cnt_d   = byte_cnt_q + 16'd1;
            if (last_byte) begin
                buf_valid_d = 1'b0;
                if (buf_last_q) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end else begin
                buf_data_d = {buf_data_q[CROSS_DATA_WIDTH-9:0], 8'h00};
                byte_idx_d = byte_idx_q + CW'(1);
            end
        end

        if (irq_d) begin
            seq_out_d  = seq_cnt_q;
            addr_out_d = addr_cnt_q;
            seq_cnt_d  = seq_cnt_q + 8'd1;
            addr_cnt_d = (addr_cnt_q == 8'(TS_ADDR_DEPTH - 1)) ? 8'd0 : addr_cnt_q + 8'd1;
        end

        if (accept) begin
            if (state_q == DROP) begin
                if (i_mac_cross_axi_data_last) state_d = IDLE;
            end else if (new_frame && !i_mac_port_link) begin
                state_d = i_mac_cross_axi_data_last ? IDLE : DROP;
            end else begin
                state_d     = SEND;
                buf_data_d  = i_mac_cross_port_axi_data[CROSS_DATA_WIDTH-1:0];
                buf_valid_d = 1'b1;
                buf_last_d  = i_mac_cross_axi_data_last;
                byte_idx_d  = '0;
                cnt_d       = keep_cnt;
                err_acc_d   = new_frame ? err_in : (err_acc_q | err_in);
                if (new_frame) first_byte_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            buf_data_q   <= '0;
            buf_valid_q  <= 1'b0;
            buf_last_q   <= 1'b0;
            byte_idx_q   <= '0;
            cnt_q        <= '0;
            err_acc_q    <= 1'b0;
            first_byte_q <= 1'b0;
            irq_q        <= 1'b0;
            seq_cnt_q    <= '0;
            addr_cnt_q   <= '0;
            seq_out_q    <= '0;
            addr_out_q   <= '0;
            byte_cnt_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            buf_data_q   <= buf_data_d;
            buf_valid_q  <= buf_valid_d;
            buf_last_q   <= buf_last_d;
            byte_idx_q   <= byte_idx_d;
            cnt_q        <= cnt_d;
            err_acc_q    <= err_acc_d;
            first_byte_q <= first_byte_d;
            irq_q        <= irq_d;
            seq_cnt_q    <= seq_cnt_d;
            addr_cnt_q   <= addr_cnt_d;
            seq_out_q    <= seq_out_d;
            addr_out_q   <= addr_out_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign o_mac_cross_axi_data_ready = ready;
    assign o_mac_axi_data             = buf_data_q[CROSS_DATA_WIDTH-1 -: 8];
    assign o_mac_axi_data_valid       = buf_valid_q;
    assign o_mac_axi_data_keep        = buf_valid_q;
    assign o_mac_axi_data_last        = buf_valid_q & buf_last_q & last_byte;
    assign o_mac_axi_data_err         = buf_valid_q & buf_last_q & last_byte & err_acc_q;
    assign o_mac_time_irq             = irq_q;
    assign o_mac_frame_seq            = seq_out_q;
    assign o_timestamp_addr           = addr_out_q;
    assign o_port_tx_byte_cnt         = byte_cnt_q;
    assign o_port_tx_frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_tx_data_stream_cross.sv
// Directed bench for tx_data_stream_cross: frame streams, drops, backpressure, errors, timestamps.
module tb_tx_data_stream_cross;

    localparam int CDW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          link = 1'b1;
    logic [CDW:0]  cross_data = '0;
    logic [3:0]    cross_keep = '0;
    logic          cross_valid = 1'b0;
    logic          cross_ready;
    logic          cross_last = 1'b0;
    logic [7:0]    mac_data;
    logic          mac_keep;
    logic          mac_valid;
    logic          mac_ready = 1'b1;
    logic          mac_last;
    logic          mac_err;
    logic          time_irq;
    logic [7:0]    frame_seq;
    logic [7:0]    ts_addr;
    logic [15:0]   byte_cnt;
    logic [15:0]   frame_cnt;

    tx_data_stream_cross #(
        .PORT_NUM(4), .PORT_MNG_DATA_WIDTH(8), .CROSS_DATA_WIDTH(CDW), .TS_ADDR_DEPTH(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_mac_port_link(link),
        .i_mac_cross_port_axi_data(cross_data), .i_mac_cross_axi_data_keep(cross_keep),
        .i_mac_cross_axi_data_valid(cross_valid), .o_mac_cross_axi_data_ready(cross_ready),
        .i_mac_cross_axi_data_last(cross_last),
        .o_mac_axi_data(mac_data), .o_mac_axi_data_keep(mac_keep),
        .o_mac_axi_data_valid(mac_valid), .i_mac_axi_data_ready(mac_ready),
        .o_mac_axi_data_last(mac_last), .o_mac_axi_data_err(mac_err),
        .o_mac_time_irq(time_irq), .o_mac_frame_seq(frame_seq), .o_timestamp_addr(ts_addr),
        .o_port_tx_byte_cnt(byte_cnt), .o_port_tx_frame_cnt(frame_cnt)
    );

    always #2 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int first_acc_cyc = 0;
    bit stall_mode   = 1'b0;

    logic [7:0] rx_data[$];
    logic       rx_last[$];
    logic       rx_err[$];
    int         rx_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    logic       exp_err[$];
    int         irq_seq[$];
    int         irq_addr[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        mac_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic       prev_err   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", 32'(mac_valid), 32'd1);
                check_eq("hold_data", 32'(mac_data), 32'(prev_data));
                check_eq("hold_last", 32'(mac_last), 32'(prev_last));
                check_eq("hold_err", 32'(mac_err), 32'(prev_err));
            end
            if (mac_valid && mac_ready) begin
                check_eq("keep", 32'(mac_keep), 32'd1);
                rx_data.push_back(mac_data);
                rx_last.push_back(mac_last);
                rx_err.push_back(mac_err);
                rx_cyc.push_back(cyc);
            end
            if (time_irq) begin
                irq_seq.push_back(int'(frame_seq));
                irq_addr.push_back(int'(ts_addr));
            end
            prev_stall = mac_valid & ~mac_ready;
            prev_data  = mac_data;
            prev_last  = mac_last;
            prev_err   = mac_err;
        end
    end

    task automatic clear_queues();
        rx_data.delete(); rx_last.delete(); rx_err.delete(); rx_cyc.delete();
        exp_data.delete(); exp_last.delete(); exp_err.delete();
        irq_seq.delete(); irq_addr.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cross_valid = 1'b0;
        stall_mode = 1'b0;
        link = 1'b1;
        clear_queues();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic e, output int waits, output int acc_cyc);
        cross_data  = {e, d};
        cross_keep  = k;
        cross_last  = l;
        cross_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!cross_ready && waits < 500);
        acc_cyc = cyc;
        check_eq("beat_accepted", 32'(cross_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int fid, input int nbeats, input logic [3:0] last_keep,
                              input int err_beat, input bit expect_tx, input bit raise_link);
        int w, c, nb;
        logic [31:0] d;
        logic [3:0] k;
        logic lst;
        bit ferr;
        ferr = (err_beat >= 0) && (err_beat < nbeats);
        for (int b = 0; b < nbeats; b++) begin
            k  = (b == nbeats - 1) ? last_keep : 4'hF;
            nb = $countones(k);
            for (int j = 0; j < 4; j++) d[31-8*j -: 8] = 8'(fid * 53 + b * 4 + j + 7);
            if (expect_tx) begin
                for (int j = 0; j < nb; j++) begin
                    lst = (b == nbeats - 1) && (j == nb - 1);
                    exp_data.push_back(d[31-8*j -: 8]);
                    exp_last.push_back(lst);
                    exp_err.push_back(lst & ferr);
                end
            end
            push_beat(d, k, 1'(b == nbeats - 1), 1'(b == err_beat), w, c);
            if (b == 0) first_acc_cyc = c;
            if (!expect_tx) check_eq("drop_ready_wait", 32'(w), 32'd1);
            if (raise_link && b == 0) link = 1'b1;
        end
        cross_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int w = 0;
        int n;
        while (rx_data.size() < exp_data.size() && w < 3000) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        check_eq({tag, "_len"}, 32'(rx_data.size()), 32'(exp_data.size()));
        n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_byte"}, 32'(rx_data[i]), 32'(exp_data[i]));
            check_eq({tag, "_last"}, 32'(rx_last[i]), 32'(exp_last[i]));
            check_eq({tag, "_err"}, 32'(rx_err[i]), 32'(exp_err[i]));
        end
    endtask

    task automatic check_stats(input string tag, input int bytes, input int frames);
        check_eq({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(bytes));
        check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(frames));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(cross_ready), 32'd0);
        check_eq("rst_valid", 32'(mac_valid), 32'd0);
        check_eq("rst_data", 32'(mac_data), 32'd0);
        check_eq("rst_last", 32'(mac_last), 32'd0);
        check_eq("rst_err", 32'(mac_err), 32'd0);
        check_eq("rst_irq", 32'(time_irq), 32'd0);
        check_eq("rst_seq", 32'(frame_seq), 32'd0);
        check_eq("rst_addr", 32'(ts_addr), 32'd0);
        check_stats("rst", 0, 0);
        rst = 1'b0;

        // single 64-byte frame, no backpressure
        send_frame(1, 16, 4'hF, -1, 1'b1, 1'b0);
        wait_drain("f64");
        if (rx_cyc.size() == 64) begin
            check_eq("f64_latency", 32'(rx_cyc[0] - first_acc_cyc), 32'd1);
            check_eq("f64_contig", 32'(rx_cyc[63] - rx_cyc[0]), 32'd63);
        end
        check_eq("f64_irq_cnt", 32'(irq_seq.size()), 32'd1);
        if (irq_seq.size() > 0) begin
            check_eq("f64_seq", 32'(irq_seq[0]), 32'd0);
            check_eq("f64_addr", 32'(irq_addr[0]), 32'd0);
        end
        check_stats("f64", 64, 1);

        // 61-byte frame, partial last beat
        do_reset();
        send_frame(2, 16, 4'b1000, -1, 1'b1, 1'b0);
        wait_drain("f61");
        check_stats("f61", 61, 1);

        // link down at frame start, rising mid-frame, then a single-beat drop
        do_reset();
        link = 1'b0;
        send_frame(10, 5, 4'hF, -1, 1'b0, 1'b1);
        link = 1'b0;
        send_frame(11, 1, 4'hF, -1, 1'b0, 1'b0);
        link = 1'b1;
        wait_drain("drop");
        check_eq("drop_irq_cnt", 32'(irq_seq.size()), 32'd0);
        check_stats("drop", 0, 0);
        send_frame(12, 3, 4'hF, -1, 1'b1, 1'b0);
        wait_drain("after_drop");
        check_eq("after_drop_irq_cnt", 32'(irq_seq.size()), 32'd1);
        if (irq_seq.size() > 0) check_eq("after_drop_seq", 32'(irq_seq[0]), 32'd0);
        check_stats("after_drop", 12, 1);

        // random MAC backpressure across three back-to-back frames
        do_reset();
        stall_mode = 1'b1;
        send_frame(30, 4, 4'hF, -1, 1'b1, 1'b0);
        send_frame(31, 3, 4'b1100, -1, 1'b1, 1'b0);
        send_frame(32, 2, 4'hF, -1, 1'b1, 1'b0);
        wait_drain("stall");
        stall_mode = 1'b0;
        check_eq("stall_irq_cnt", 32'(irq_seq.size()), 32'd3);
        for (int i = 0; i < irq_seq.size(); i++) check_eq("stall_seq", 32'(irq_seq[i]), 32'(i));
        check_stats("stall", 34, 3);

        // error on beat 3 of 5, followed by a clean frame
        do_reset();
        send_frame(20, 5, 4'hF, 2, 1'b1, 1'b0);
        send_frame(21, 2, 4'hF, -1, 1'b1, 1'b0);
        wait_drain("err");
        check_stats("err", 28, 2);

        // timestamp address wrap over 17 frames
        do_reset();
        for (int f = 0; f < 17; f++) send_frame(40 + f, 1, 4'hF, -1, 1'b1, 1'b0);
        wait_drain("wrap");
        check_eq("wrap_irq_cnt", 32'(irq_seq.size()), 32'd17);
        for (int i = 0; i < irq_seq.size(); i++) begin
            check_eq("wrap_seq", 32'(irq_seq[i]), 32'(i));
            check_eq("wrap_addr", 32'(irq_addr[i]), 32'(i % 16));
        end
        check_eq("wrap_seq_hold", 32'(frame_seq), 32'd16);
        check_eq("wrap_addr_hold", 32'(ts_addr), 32'd0);
        check_stats("wrap", 68, 17);

        // reset in the middle of a frame
        push_beat(32'hA1A2A3A4, 4'hF, 1'b0, 1'b0, w, c);
        push_beat(32'hB1B2B3B4, 4'hF, 1'b0, 1'b0, w, c);
        cross_valid = 1'b0;
        rst = 1'b1;
        clear_queues();
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", 32'(mac_valid), 32'd0);
        check_eq("midrst_ready", 32'(cross_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(99, 2, 4'hF, -1, 1'b1, 1'b0);
        wait_drain("post_rst");
        check_eq("post_rst_irq_cnt", 32'(irq_seq.size()), 32'd1);
        if (irq_seq.size() > 0) begin
            check_eq("post_rst_seq", 32'(irq_seq[0]), 32'd0);
            check_eq("post_rst_addr", 32'(irq_addr[0]), 32'd0);
        end
        check_stats("post_rst", 8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
